a2d_arbiter: RTL and testbench

//  Shares one A2D_intf SPI converter between two requesters: port 0 = IR sensor sweep, port 1 = battery/aux monitor.

---
 rtl/a2d_arb_pkg.sv | 37 +++
 rtl/a2d_arb_req_slot.sv | 78 +++++++
 rtl/a2d_arbiter.sv | 179 +++++++++++++++++
 tb/tb_a2d_arbiter.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/a2d_arb_pkg.sv
// -----------------------------------------------------------------------------
// a2d_arb_pkg
// Shared types and defaults for the two-port A2D converter arbiter.
//   state_t     : arbiter FSM states (IDLE, ISSUE, WAIT)
//   DEF_*       : default widths for channel select, result and timeout counter
//   pick_winner : arbitration rule between the two request slots
// -----------------------------------------------------------------------------
package a2d_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam int DEF_CH_W  = 3;
  localparam int DEF_RES_W = 12;
  localparam int DEF_TMO_W = 14;

  // On a tie, round-robin hands the converter to the port not granted last;
  // fixed priority always favours port 0. Without a tie the pending port wins.
  function automatic logic pick_winner(input logic pend0,
                                       input logic pend1,
                                       input logic last_grant,
                                       input logic prio_fixed);
    logic win;
    if (pend0 && pend1) begin
      win = prio_fixed ? 1'b0 : ~last_grant;
    end else if (pend1) begin
      win = 1'b1;
    end else begin
      win = 1'b0;
    end
    return win;
  endfunction

endpackage

// File: rtl/a2d_arb_req_slot.sv
// -----------------------------------------------------------------------------
// a2d_arb_req_slot
// One requester's view of the shared converter: accepts a start pulse when
// idle, latches its channel, holds the pending flag until the conversion ends,
// then stores the result and emits a one-cycle completion pulse.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   strt_i       : one-cycle request pulse (ignored while pending)
//   chnnl_i      : channel sampled with strt_i
//   done_i       : this slot's conversion finished (owner-qualified by top)
//   res_i        : result to store when done_i is high
//   pending_o    : request pending or in service (drives the busy output)
//   chnnl_o      : latched channel
//   cmplt_o      : registered one-cycle done pulse
//   res_o        : last result, held until the next completion
// -----------------------------------------------------------------------------
module a2d_arb_req_slot
  import a2d_arb_pkg::*;
#(
  parameter int CH_W  = DEF_CH_W,
  parameter int RES_W = DEF_RES_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             strt_i,
  input  logic [CH_W-1:0]  chnnl_i,
  input  logic             done_i,
  input  logic [RES_W-1:0] res_i,
  output logic             pending_o,
  output logic [CH_W-1:0]  chnnl_o,
  output logic             cmplt_o,
  output logic [RES_W-1:0] res_o
);

  logic             pending_q, pending_d;
  logic [CH_W-1:0]  chnnl_q, chnnl_d;
  logic             cmplt_q, cmplt_d;
  logic [RES_W-1:0] res_q, res_d;

  // Slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      chnnl_q   <= {CH_W{1'b0}};
      cmplt_q   <= 1'b0;
      res_q     <= {RES_W{1'b0}};
    end else begin
      pending_q <= pending_d;
      chnnl_q   <= chnnl_d;
      cmplt_q   <= cmplt_d;
      res_q     <= res_d;
    end
  end

  // Next-state: completion clears the slot; a start only lands on an idle slot,
  // so a repeated start while busy neither overwrites nor queues.
  always_comb begin
    pending_d = pending_q;
    chnnl_d   = chnnl_q;
    res_d     = res_q;
    cmplt_d   = done_i;
    if (done_i) begin
      pending_d = 1'b0;
      res_d     = res_i;
    end else if (strt_i && !pending_q) begin
      pending_d = 1'b1;
      chnnl_d   = chnnl_i;
    end else begin
      pending_d = pending_q;
    end
  end

  assign pending_o = pending_q;
  assign chnnl_o   = chnnl_q;
  assign cmplt_o   = cmplt_q;
  assign res_o     = res_q;

endmodule

// File: rtl/a2d_arbiter.sv
// -----------------------------------------------------------------------------
// a2d_arbiter
// Shares one A2D_intf SPI converter between port 0 (IR sweep) and port 1
// (battery/aux monitor). Start pulses are latched per port, one owner at a
// time gets the converter, and cmplt/res are routed back to the owner only.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   reqN_strt / reqN_chnnl     : request pulse and channel (N = 0, 1)
//   reqN_busy                  : request pending or in service
//   reqN_cmplt / reqN_res      : done pulse and held result for the owner
//   a2d_strt_cnv / a2d_chnnl   : start pulse and channel to A2D_intf
//   a2d_cnv_cmplt / a2d_res    : done and result from A2D_intf
//   err                        : one-cycle timeout pulse
// Configuration:
//   A2D_ARB_TIMEOUT_EN : when defined, a TMO_W-bit counter aborts a conversion
//                        that never completes; otherwise WAIT is unbounded and
//                        err is tied low.
// -----------------------------------------------------------------------------
module a2d_arbiter
  import a2d_arb_pkg::*;
#(
  parameter int PRIO_FIXED = 0,
  parameter int CH_W       = DEF_CH_W,
  parameter int RES_W      = DEF_RES_W,
  parameter int TMO_W      = DEF_TMO_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_strt,
  input  logic [CH_W-1:0]  req0_chnnl,
  output logic             req0_busy,
  output logic             req0_cmplt,
  output logic [RES_W-1:0] req0_res,
  input  logic             req1_strt,
  input  logic [CH_W-1:0]  req1_chnnl,
  output logic             req1_busy,
  output logic             req1_cmplt,
  output logic [RES_W-1:0] req1_res,
  output logic             a2d_strt_cnv,
  output logic [CH_W-1:0]  a2d_chnnl,
  input  logic             a2d_cnv_cmplt,
  input  logic [RES_W-1:0] a2d_res,
  output logic             err
);

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_grant_q, last_grant_d;
  logic [CH_W-1:0]  chnnl_q, chnnl_d;
  logic             win_s;
  logic             pend0_s, pend1_s;
  logic [CH_W-1:0]  slot_ch0_s, slot_ch1_s;
  logic             done_s, tmo_hit_s;
  logic [RES_W-1:0] done_res_s;

  // A conversion ends on the converter's done, or on timeout; a cmplt in any
  // other state is dropped here and never reaches either slot.
  assign done_s     = (state_q == WAIT) && (a2d_cnv_cmplt || tmo_hit_s);
  assign done_res_s = a2d_cnv_cmplt ? a2d_res : {RES_W{1'b1}};

  a2d_arb_req_slot #(.CH_W(CH_W), .RES_W(RES_W)) u_slot0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .strt_i    (req0_strt),
    .chnnl_i   (req0_chnnl),
    .done_i    (done_s && !owner_q),
    .res_i     (done_res_s),
    .pending_o (pend0_s),
    .chnnl_o   (slot_ch0_s),
    .cmplt_o   (req0_cmplt),
    .res_o     (req0_res)
  );

  a2d_arb_req_slot #(.CH_W(CH_W), .RES_W(RES_W)) u_slot1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .strt_i    (req1_strt),
    .chnnl_i   (req1_chnnl),
    .done_i    (done_s && owner_q),
    .res_i     (done_res_s),
    .pending_o (pend1_s),
    .chnnl_o   (slot_ch1_s),
    .cmplt_o   (req1_cmplt),
    .res_o     (req1_res)
  );

  assign req0_busy = pend0_s;
  assign req1_busy = pend1_s;

  // FSM state, owner, grant history and converter channel registers.
  // last_grant resets to port 1 so port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      chnnl_q      <= {CH_W{1'b0}};
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      chnnl_q      <= chnnl_d;
    end
  end

  // Next-state: arbitrate in IDLE, pulse start in ISSUE, wait for completion.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    chnnl_d      = chnnl_q;
    win_s        = pick_winner(pend0_s, pend1_s, last_grant_q, (PRIO_FIXED != 0));
    case (state_q)
      IDLE: begin
        if (pend0_s || pend1_s) begin
          owner_d      = win_s;
          last_grant_d = win_s;
          chnnl_d      = win_s ? slot_ch1_s : slot_ch0_s;
          state_d      = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (done_s) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state; the channel register holds steady
  // from the start pulse through completion.
  always_comb begin
    a2d_strt_cnv = (state_q == ISSUE);
    a2d_chnnl    = chnnl_q;
  end

`ifdef A2D_ARB_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             err_q;

  // A converter done in the same cycle as the terminal count still wins.
  assign tmo_hit_s = (state_q == WAIT) && (&tmo_cnt_q) && !a2d_cnv_cmplt;

  // Timeout counter: restarts at every start pulse, advances only in WAIT.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == ISSUE) begin
      tmo_cnt_d = {TMO_W{1'b0}};
    end else if (state_q == WAIT) begin
      tmo_cnt_d = tmo_cnt_q + {{(TMO_W-1){1'b0}}, 1'b1};
    end else begin
      tmo_cnt_d = tmo_cnt_q;
    end
  end

  // Timeout counter and error pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= {TMO_W{1'b0}};
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= tmo_hit_s;
    end
  end

  assign err = err_q;
`else
  assign tmo_hit_s = 1'b0;
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_a2d_arbiter.sv
// -----------------------------------------------------------------------------
// tb_a2d_arbiter
// Self-checking bench for a2d_arbiter. The main instance (round-robin) is
// tracked by a transaction-level model of the converter sharing rules; a
// second instance with fixed priority and a 4-bit timeout shares the inputs
// and is checked by directed scenarios only.
// -----------------------------------------------------------------------------
module tb_a2d_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_strt, req1_strt, a2d_cnv_cmplt;
  logic [2:0]  req0_chnnl, req1_chnnl;
  logic [11:0] a2d_res;

  logic        req0_busy, req0_cmplt, req1_busy, req1_cmplt, a2d_strt_cnv, err;
  logic [11:0] req0_res, req1_res;
  logic [2:0]  a2d_chnnl;

  logic        f_req0_busy, f_req0_cmplt, f_req1_busy, f_req1_cmplt, f_strt, f_err;
  logic [11:0] f_req0_res, f_req1_res;
  logic [2:0]  f_chnnl;

  int errors = 0;
  int checks = 0;

  // Reference model: per-port pending/channel/result, converter phase
  // (0 free, 1 start-pulse cycle, 2 converting), owner and last grant.
  bit          m_pend [2];
  logic [2:0]  m_ch   [2];
  logic [11:0] m_res  [2];
  bit          m_cmplt[2];
  int          m_phase;
  bit          m_owner, m_lastg;
  logic [2:0]  m_achn;

  always #5 clk = ~clk;

  a2d_arbiter #(.PRIO_FIXED(0), .CH_W(3), .RES_W(12), .TMO_W(14)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_strt(req0_strt), .req0_chnnl(req0_chnnl), .req0_busy(req0_busy),
    .req0_cmplt(req0_cmplt), .req0_res(req0_res),
    .req1_strt(req1_strt), .req1_chnnl(req1_chnnl), .req1_busy(req1_busy),
    .req1_cmplt(req1_cmplt), .req1_res(req1_res),
    .a2d_strt_cnv(a2d_strt_cnv), .a2d_chnnl(a2d_chnnl),
    .a2d_cnv_cmplt(a2d_cnv_cmplt), .a2d_res(a2d_res), .err(err)
  );

  a2d_arbiter #(.PRIO_FIXED(1), .CH_W(3), .RES_W(12), .TMO_W(4)) u_fix (
    .clk(clk), .rst_n(rst_n),
    .req0_strt(req0_strt), .req0_chnnl(req0_chnnl), .req0_busy(f_req0_busy),
    .req0_cmplt(f_req0_cmplt), .req0_res(f_req0_res),
    .req1_strt(req1_strt), .req1_chnnl(req1_chnnl), .req1_busy(f_req1_busy),
    .req1_cmplt(f_req1_cmplt), .req1_res(f_req1_res),
    .a2d_strt_cnv(f_strt), .a2d_chnnl(f_chnnl),
    .a2d_cnv_cmplt(a2d_cnv_cmplt), .a2d_res(a2d_res), .err(f_err)
  );

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_pend[p] = 1'b0; m_ch[p] = 3'd0; m_res[p] = 12'd0; m_cmplt[p] = 1'b0;
    end
    m_phase = 0; m_owner = 1'b0; m_lastg = 1'b1; m_achn = 3'd0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit         done, old_owner, w;
    bit         s[2];
    logic [2:0] c[2];
    s[0] = req0_strt; s[1] = req1_strt; c[0] = req0_chnnl; c[1] = req1_chnnl;
    old_owner = m_owner;
    done = (m_phase == 2) && (a2d_cnv_cmplt === 1'b1);
    m_cmplt[0] = done && !old_owner;
    m_cmplt[1] = done && old_owner;
    for (int p = 0; p < 2; p++) if (m_cmplt[p]) m_res[p] = a2d_res;
    if (m_phase == 0 && (m_pend[0] || m_pend[1])) begin
      w = (m_pend[0] && m_pend[1]) ? !m_lastg : m_pend[1];
      m_owner = w; m_lastg = w; m_achn = m_ch[w]; m_phase = 1;
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (done) begin
      m_phase = 0;
    end
    for (int p = 0; p < 2; p++) begin
      if (done && (old_owner == p[0])) m_pend[p] = 1'b0;
      else if (s[p] && !m_pend[p]) begin m_pend[p] = 1'b1; m_ch[p] = c[p]; end
    end
  endtask

  // One clock: update model, pass the edge, sample 1 time unit later, clear pulses.
  task automatic tick();
    model_edge();
    @(posedge clk); #1;
    req0_strt = 1'b0; req1_strt = 1'b0; a2d_cnv_cmplt = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req0_strt = 1'b0; req1_strt = 1'b0; a2d_cnv_cmplt = 1'b0;
    req0_chnnl = 3'd0; req1_chnnl = 3'd0; a2d_res = 12'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  // Wait (bounded) for a start pulse on the main instance, then complete it.
  task automatic serve(input int dly, input logic [11:0] res,
                       output logic [2:0] ch, output logic [1:0] cm, output bit to);
    int n = 0;
    while (a2d_strt_cnv !== 1'b1 && n < 50) begin tick(); n++; end
    to = (a2d_strt_cnv !== 1'b1);
    ch = a2d_chnnl;
    repeat (dly) tick();
    a2d_cnv_cmplt = 1'b1; a2d_res = res;
    tick();
    cm = {req1_cmplt, req0_cmplt};
  endtask

  task automatic wait_fix_strt(output bit to);
    int n = 0;
    while (f_strt !== 1'b1 && n < 50) begin tick(); n++; end
    to = (f_strt !== 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({req0_busy, req0_cmplt, req0_res, req1_busy, req1_cmplt, req1_res,
         a2d_strt_cnv, a2d_chnnl, err} !== 32'd0) begin
      errors++; $display("FAIL reset_main: outputs not all zero");
    end
    checks++;
    if ({f_req0_busy, f_req0_cmplt, f_req0_res, f_req1_busy, f_req1_cmplt, f_req1_res,
         f_strt, f_chnnl, f_err} !== 32'd0) begin
      errors++; $display("FAIL reset_fix: outputs not all zero");
    end
  endtask

  task automatic test_single();
    req0_strt = 1'b1; req0_chnnl = 3'd5;
    tick();
    checks++;
    if (req0_busy !== 1'b1 || a2d_strt_cnv !== 1'b0) begin
      errors++; $display("FAIL single_busy: busy=%b strt=%b want 1 0", req0_busy, a2d_strt_cnv);
    end
    tick();
    checks++;
    if (a2d_strt_cnv !== 1'b1 || a2d_chnnl !== 3'd5) begin
      errors++; $display("FAIL single_start: strt=%b ch=%0d want 1 5", a2d_strt_cnv, a2d_chnnl);
    end
    tick();
    checks++;
    if (a2d_strt_cnv !== 1'b0 || a2d_chnnl !== 3'd5) begin
      errors++; $display("FAIL single_pulse: strt=%b ch=%0d want 0 5", a2d_strt_cnv, a2d_chnnl);
    end
    repeat (17) tick();
    a2d_cnv_cmplt = 1'b1; a2d_res = 12'h3A7;
    tick();
    checks++;
    if (req0_cmplt !== 1'b1 || req0_res !== 12'h3A7 || req0_busy !== 1'b0) begin
      errors++; $display("FAIL single_done: cmplt=%b res=%h busy=%b want 1 3a7 0",
                         req0_cmplt, req0_res, req0_busy);
    end
    checks++;
    if (req1_cmplt !== 1'b0 || req1_res !== 12'h000 || req1_busy !== 1'b0) begin
      errors++; $display("FAIL single_other: cmplt=%b res=%h busy=%b want 0 000 0",
                         req1_cmplt, req1_res, req1_busy);
    end
    tick();
    checks++;
    if (req0_cmplt !== 1'b0) begin
      errors++; $display("FAIL single_once: cmplt=%b want 0", req0_cmplt);
    end
  endtask

  task automatic test_tie();
    logic [2:0] ch; logic [1:0] cm; bit to;
    do_reset();
    req0_strt = 1'b1; req0_chnnl = 3'd2; req1_strt = 1'b1; req1_chnnl = 3'd6;
    tick();
    serve(3, 12'h111, ch, cm, to);
    checks++;
    if (to || ch !== 3'd2 || cm !== 2'b01) begin
      errors++; $display("FAIL tie1_first: to=%b ch=%0d cm=%b want 0 2 01", to, ch, cm);
    end
    serve(2, 12'h222, ch, cm, to);
    checks++;
    if (to || ch !== 3'd6 || cm !== 2'b10 || req1_res !== 12'h222 || req0_res !== 12'h111) begin
      errors++; $display("FAIL tie1_second: ch=%0d cm=%b r0=%h r1=%h want 6 10 111 222",
                         ch, cm, req0_res, req1_res);
    end
    req0_strt = 1'b1; req0_chnnl = 3'd2;
    tick();
    serve(1, 12'h333, ch, cm, to);
    checks++;
    if (to || ch !== 3'd2 || cm !== 2'b01) begin
      errors++; $display("FAIL tie_solo: ch=%0d cm=%b want 2 01", ch, cm);
    end
    req0_strt = 1'b1; req0_chnnl = 3'd2; req1_strt = 1'b1; req1_chnnl = 3'd6;
    tick();
    serve(1, 12'h444, ch, cm, to);
    checks++;
    if (to || ch !== 3'd6 || cm !== 2'b10) begin
      errors++; $display("FAIL tie2_first: ch=%0d cm=%b want 6 10", ch, cm);
    end
    serve(1, 12'h555, ch, cm, to);
    checks++;
    if (to || ch !== 3'd2 || cm !== 2'b01) begin
      errors++; $display("FAIL tie2_second: ch=%0d cm=%b want 2 01", ch, cm);
    end
  endtask

  task automatic test_prio_fixed();
    bit to;
    do_reset();
    for (int r = 0; r < 3; r++) begin
      req0_strt = 1'b1; req0_chnnl = 3'd2; req1_strt = 1'b1; req1_chnnl = 3'd6;
      tick();
      wait_fix_strt(to);
      checks++;
      if (to || f_chnnl !== 3'd2) begin
        errors++; $display("FAIL prio_first r%0d: to=%b ch=%0d want 0 2", r, to, f_chnnl);
      end
      repeat (2) tick();
      a2d_cnv_cmplt = 1'b1; a2d_res = 12'h0A0;
      tick();
      wait_fix_strt(to);
      checks++;
      if (to || f_chnnl !== 3'd6) begin
        errors++; $display("FAIL prio_second r%0d: to=%b ch=%0d want 0 6", r, to, f_chnnl);
      end
      repeat (2) tick();
      a2d_cnv_cmplt = 1'b1; a2d_res = 12'h0B0;
      tick();
      checks++;
      if (f_req1_cmplt !== 1'b1 || f_req1_res !== 12'h0B0) begin
        errors++; $display("FAIL prio_done r%0d: cmplt=%b res=%h want 1 0b0",
                           r, f_req1_cmplt, f_req1_res);
      end
    end
  endtask

  task automatic test_busy_ignore();
    logic [2:0] ch; logic [1:0] cm; bit to; int n;
    req1_strt = 1'b1; req1_chnnl = 3'd7;
    tick();
    req1_strt = 1'b1; req1_chnnl = 3'd1;
    tick();
    serve(2, 12'h5A5, ch, cm, to);
    checks++;
    if (to || ch !== 3'd7 || cm !== 2'b10 || req1_res !== 12'h5A5) begin
      errors++; $display("FAIL busy_conv: ch=%0d cm=%b res=%h want 7 10 5a5", ch, cm, req1_res);
    end
    n = 0;
    repeat (10) begin tick(); if (a2d_strt_cnv === 1'b1 || req1_cmplt === 1'b1) n++; end
    checks++;
    if (n != 0 || req1_busy !== 1'b0) begin
      errors++; $display("FAIL busy_extra: extra_events=%0d busy=%b want 0 0", n, req1_busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] ch; logic [1:0] cm; bit to;
    req0_strt = 1'b1; req0_chnnl = 3'd3;
    tick();
    serve(1, 12'h123, ch, cm, to);
    checks++;
    if (cm !== 2'b01 || req0_busy !== 1'b0) begin
      errors++; $display("FAIL b2b_done: cm=%b busy=%b want 01 0", cm, req0_busy);
    end
    req0_strt = 1'b1; req0_chnnl = 3'd4;
    tick();
    checks++;
    if (req0_busy !== 1'b1) begin
      errors++; $display("FAIL b2b_accept: busy=%b want 1", req0_busy);
    end
    tick();
    checks++;
    if (a2d_strt_cnv !== 1'b1 || a2d_chnnl !== 3'd4) begin
      errors++; $display("FAIL b2b_start: strt=%b ch=%0d want 1 4", a2d_strt_cnv, a2d_chnnl);
    end
    serve(1, 12'h456, ch, cm, to);
    checks++;
    if (cm !== 2'b01 || req0_res !== 12'h456) begin
      errors++; $display("FAIL b2b_second: cm=%b res=%h want 01 456", cm, req0_res);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    req0_strt = 1'b1; req0_chnnl = 3'd3;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({req0_busy, req0_cmplt, req0_res, req1_busy, req1_cmplt, req1_res,
         a2d_strt_cnv, a2d_chnnl, err} !== 32'd0) begin
      errors++; $display("FAIL rstmid_async: b0=%b r0=%h ch=%0d want all zero",
                         req0_busy, req0_res, a2d_chnnl);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    a2d_cnv_cmplt = 1'b1; a2d_res = 12'hABC;
    tick();
    checks++;
    if (req0_cmplt !== 1'b0 || req1_cmplt !== 1'b0 || req0_res !== 12'h000) begin
      errors++; $display("FAIL rstmid_late: c0=%b c1=%b r0=%h want 0 0 000",
                         req0_cmplt, req1_cmplt, req0_res);
    end
    n = 0;
    repeat (5) begin tick(); if (a2d_strt_cnv === 1'b1 || req0_busy === 1'b1) n++; end
    checks++;
    if (n != 0) begin
      errors++; $display("FAIL rstmid_idle: activity=%0d want 0", n);
    end
  endtask

`ifdef A2D_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit to; int n;
    do_reset();
    req0_strt = 1'b1; req0_chnnl = 3'd4;
    tick();
    wait_fix_strt(to);
    n = 0;
    while (f_err !== 1'b1 && n < 40) begin tick(); n++; end
    checks++;
    if (to || n != 17) begin
      errors++; $display("FAIL tmo_delay: got %0d cycles want 17", n);
    end
    checks++;
    if (f_req0_cmplt !== 1'b1 || f_req0_res !== 12'hFFF || f_req0_busy !== 1'b0) begin
      errors++; $display("FAIL tmo_owner: cmplt=%b res=%h busy=%b want 1 fff 0",
                         f_req0_cmplt, f_req0_res, f_req0_busy);
    end
    req1_strt = 1'b1; req1_chnnl = 3'd1;
    tick();
    wait_fix_strt(to);
    checks++;
    if (to || f_chnnl !== 3'd1) begin
      errors++; $display("FAIL tmo_next: to=%b ch=%0d want 0 1", to, f_chnnl);
    end
    a2d_cnv_cmplt = 1'b1; a2d_res = 12'h0C3;
    tick();
    tick();
    checks++;
    if (f_req1_cmplt !== 1'b1 || f_req1_res !== 12'h0C3 || f_err !== 1'b0) begin
      errors++; $display("FAIL tmo_recover: cmplt=%b res=%h err=%b want 1 0c3 0",
                         f_req1_cmplt, f_req1_res, f_err);
    end
  endtask
`endif

  task automatic test_random();
    bit bad;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      req0_strt     = ($urandom_range(0, 3) == 0);
      req0_chnnl    = 3'($urandom_range(0, 7));
      req1_strt     = ($urandom_range(0, 3) == 0);
      req1_chnnl    = 3'($urandom_range(0, 7));
      a2d_cnv_cmplt = ($urandom_range(0, 4) == 0);
      a2d_res       = 12'($urandom_range(0, 4095));
      tick();
      checks++;
      bad = (req0_busy !== m_pend[0]) || (req1_busy !== m_pend[1]) ||
            (req0_cmplt !== m_cmplt[0]) || (req1_cmplt !== m_cmplt[1]) ||
            (req0_res !== m_res[0]) || (req1_res !== m_res[1]) ||
            (a2d_strt_cnv !== (m_phase == 1)) || (a2d_chnnl !== m_achn) || (err !== 1'b0);
      if (bad) begin
        errors++;
        if (errors < 20)
          $display("FAIL random c%0d: got b%b%b c%b%b r%h/%h s%b ch%0d want b%b%b c%b%b r%h/%h s%b ch%0d",
                   i, req0_busy, req1_busy, req0_cmplt, req1_cmplt, req0_res, req1_res,
                   a2d_strt_cnv, a2d_chnnl, m_pend[0], m_pend[1], m_cmplt[0], m_cmplt[1],
                   m_res[0], m_res[1], (m_phase == 1), m_achn);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_prio_fixed();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
`ifdef A2D_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
